// File: rtl/mem_readout_pkg.sv
// Shared constants, types and stream-word packing for the projection memory readout.
// The stream word is {BX_pipe, mem_idx, mem_dat}, with BX_pipe in the MSBs.
package mem_readout_pkg;

  localparam int unsigned NMEM      = 12;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned MAX_CNT   = 100;

  localparam int unsigned DAT_W     = 45;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned BX_W      = 3;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned CLK_CNT_W = 7;
  localparam int unsigned STREAM_W  = BX_W + IDX_W + DAT_W;

  localparam int unsigned DAT_LSB   = 0;
  localparam int unsigned IDX_LSB   = DAT_LSB + DAT_W;
  localparam int unsigned BX_LSB    = IDX_LSB + IDX_W;

  typedef logic [DAT_W-1:0]    dat_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [BX_W-1:0]     bx_t;
  typedef logic [STREAM_W-1:0] stream_t;

  localparam logic [CLK_CNT_W-1:0] MAX_CNT_V = CLK_CNT_W'(MAX_CNT);
  localparam cnt_t                 CNT_ONE   = cnt_t'(1);

  function automatic stream_t pack_word(bx_t bx, idx_t idx, dat_t dat);
    stream_t w;
    w = '0;
    w[BX_LSB +: BX_W]   = bx;
    w[IDX_LSB +: IDX_W] = idx;
    w[DAT_LSB +: DAT_W] = dat;
    return w;
  endfunction

endpackage

// File: rtl/mem_readout_if.sv
// Bundle between the projection RAMs / event control (master) and the readout block (slave).
interface mem_readout_if;
  import mem_readout_pkg::*;

  logic                 new_event;
  logic [BX_W-1:0]      BX;
  logic [CLK_CNT_W-1:0] clk_cnt;
  bx_t                  BX_pipe;
  cnt_t                 items   [NMEM];
  dat_t                 mem_dat [NMEM];
  cnt_t                 addr    [NMEM];
  stream_t              mem_dat_stream;
  logic                 valid;
  logic                 none;

  modport master (
    output new_event, BX, clk_cnt, BX_pipe, items, mem_dat,
    input  addr, mem_dat_stream, valid, none
  );

  modport slave (
    input  new_event, BX, clk_cnt, BX_pipe, items, mem_dat,
    output addr, mem_dat_stream, valid, none
  );

endinterface

// File: rtl/mem_readout_prio_enc12.sv
// Fixed-priority encoder: index of the lowest set request bit plus an any-request flag.
module prio_enc12
  import mem_readout_pkg::*;
(
  input  logic [NMEM-1:0] req,
  output idx_t            idx,
  output logic            any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Walk downwards so the lowest set bit wins.
    for (int i = NMEM - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mem_readout.sv
// Drains up to NMEM projection memories per event into one stream, lowest index first,
// one item per clock, compensating the synchronous RAM read latency.
module mem_readout
  import mem_readout_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mem_readout_if.slave bus
);

  cnt_t remaining_q [NMEM];
  cnt_t remaining_d [NMEM];
  cnt_t rdptr_q     [NMEM];
  cnt_t rdptr_d     [NMEM];
  cnt_t addr_q      [NMEM];
  cnt_t addr_d      [NMEM];
  logic none_q, none_d;

  logic [RD_LAT:0] vld_q, vld_d;
  idx_t            sel_pipe_q [RD_LAT+1];
  idx_t            sel_pipe_d [RD_LAT+1];

  logic [NMEM-1:0] req;
  idx_t            sel;
  logic            any_req;
  logic            grant;
  idx_t            sel_out;
  dat_t            dat_mux;

  // BX is carried for debug visibility only.
  logic unused_bx;
  assign unused_bx = ^bus.BX;

  always_comb begin
    for (int i = 0; i < NMEM; i++) begin
      req[i] = (remaining_q[i] != '0);
    end
  end

  prio_enc12 u_prio_enc (
    .req (req),
    .idx (sel),
    .any (any_req)
  );

  assign grant = !bus.new_event && any_req && (bus.clk_cnt < MAX_CNT_V);

  always_comb begin
    none_d = 1'b1;
    for (int i = 0; i < NMEM; i++) begin
      remaining_d[i] = remaining_q[i];
      rdptr_d[i]     = rdptr_q[i];
      addr_d[i]      = addr_q[i];
    end
    for (int i = 0; i < NMEM; i++) begin
      if (bus.new_event) begin
        remaining_d[i] = bus.items[i];
        rdptr_d[i]     = '0;
      end else if (grant && (sel == IDX_W'(i))) begin
        remaining_d[i] = remaining_q[i] - CNT_ONE;
        rdptr_d[i]     = rdptr_q[i] + CNT_ONE;
        addr_d[i]      = rdptr_q[i];
      end
      if (remaining_d[i] != '0) none_d = 1'b0;
    end
  end

  // Stage k holds the grant issued k edges ago; a new event abandons everything in flight.
  always_comb begin
    vld_d         = {vld_q[RD_LAT-1:0], grant};
    sel_pipe_d[0] = sel;
    for (int k = 1; k <= RD_LAT; k++) begin
      sel_pipe_d[k] = sel_pipe_q[k-1];
    end
    if (bus.new_event) vld_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NMEM; i++) begin
        remaining_q[i] <= '0;
        rdptr_q[i]     <= '0;
        addr_q[i]      <= '0;
      end
      none_q <= 1'b1;
      vld_q  <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        sel_pipe_q[k] <= '0;
      end
    end else begin
      remaining_q <= remaining_d;
      rdptr_q     <= rdptr_d;
      addr_q      <= addr_d;
      none_q      <= none_d;
      vld_q       <= vld_d;
      sel_pipe_q  <= sel_pipe_d;
    end
  end

  assign sel_out = sel_pipe_q[RD_LAT];

  always_comb begin
    dat_mux = '0;
    for (int i = 0; i < NMEM; i++) begin
      if (sel_out == IDX_W'(i)) dat_mux = bus.mem_dat[i];
    end
  end

  // valid leads the word by one clock so the FIFO write enable lines up downstream.
  assign bus.valid          = vld_q[RD_LAT-1];
  assign bus.mem_dat_stream = vld_q[RD_LAT] ? pack_word(bus.BX_pipe, sel_out, dat_mux) : '0;
  assign bus.none           = none_q;

  always_comb begin
    for (int i = 0; i < NMEM; i++) begin
      bus.addr[i] = addr_q[i];
    end
  end

  a_grant_in_range: assert property (@(posedge clk) disable iff (reset)
    grant |-> (sel < IDX_W'(NMEM)));

  a_none_matches_counts: assert property (@(posedge clk) disable iff (reset)
    bus.none == (req == '0));

endmodule

// File: tb/tb_mem_readout.sv
// Randomized scoreboard bench for mem_readout with a latency-2 RAM model per memory.
module tb_mem_readout;
  import mem_readout_pkg::*;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_readout_if bus ();

  mem_readout u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: address captured one edge after it changes, data out the edge after that.
  dat_t content [NMEM][64];
  cnt_t ra_q    [NMEM];

  always @(posedge clk) begin
    for (int i = 0; i < NMEM; i++) begin
      ra_q[i]        <= bus.addr[i];
      bus.mem_dat[i] <= content[i][ra_q[i]];
    end
  end

  logic [IDX_W+DAT_W-1:0] exp_q [$];
  logic [IDX_W+DAT_W-1:0] pend_q [$];
  logic [IDX_W+DAT_W-1:0] mon_e;
  int   pend_total = 0;
  int   left       = 0;
  logic g0         = 1'b0;
  logic g1         = 1'b0;
  logic word_due   = 1'b0;
  int   compares   = 0;
  int   fails      = 0;
  int   ev_items [NMEM];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    compares++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: one item is granted per edge while any item is outstanding and the budget allows.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      left = 0;
      g0   = 1'b0;
      g1   = 1'b0;
    end else if (bus.new_event) begin
      left = pend_total;
      g0   = 1'b0;
      g1   = 1'b0;
    end else begin
      g1 = g0;
      g0 = (left > 0) && (bus.clk_cnt < MAX_CNT_V);
      if (g0) left--;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      word_due = 1'b0;
    end else begin
      if (word_due) begin
        if (exp_q.size() == 0) begin
          compares++;
          fails++;
          $display("FAIL stream_extra: got %h expected no word at %0t", bus.mem_dat_stream, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_word", 64'(bus.mem_dat_stream), 64'({bus.BX_pipe, mon_e}));
        end
      end else begin
        check("stream_idle", 64'(bus.mem_dat_stream), 64'(0));
      end
      check("valid", 64'(bus.valid), 64'(g1));
      check("none", 64'(bus.none), 64'(left == 0));
      word_due = bus.valid && !bus.new_event;
      if (bus.new_event) begin
        exp_q = pend_q;
        pend_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_event();
    int tot;
    tot = 0;
    pend_q.delete();
    for (int i = 0; i < NMEM; i++) begin
      bus.items[i] = cnt_t'(ev_items[i]);
      for (int k = 0; k < ev_items[i]; k++) pend_q.push_back({IDX_W'(i), content[i][k]});
      tot += ev_items[i];
    end
    pend_total    = tot;
    bus.new_event = 1'b1;
    tick();
    bus.new_event = 1'b0;
  endtask

  task automatic drain();
    int n;
    n           = 0;
    bus.clk_cnt = '0;
    while ((left != 0 || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check("drain_done", 64'(left != 0 || exp_q.size() != 0), 64'(0));
    repeat (3) tick();
  endtask

  task automatic check_cleared();
    logic any_addr;
    any_addr = 1'b0;
    for (int i = 0; i < NMEM; i++) if (bus.addr[i] != '0) any_addr = 1'b1;
    check("rst_valid", 64'(bus.valid), 64'(0));
    check("rst_none", 64'(bus.none), 64'(1));
    check("rst_stream", 64'(bus.mem_dat_stream), 64'(0));
    check("rst_addr", 64'(any_addr), 64'(0));
  endtask

  task automatic clear_items();
    for (int i = 0; i < NMEM; i++) ev_items[i] = 0;
  endtask

  initial begin
    int ncyc;
    logic any_addr;
    reset         = 1'b1;
    bus.new_event = 1'b0;
    bus.BX        = '0;
    bus.clk_cnt   = '0;
    bus.BX_pipe   = '0;
    for (int i = 0; i < NMEM; i++) begin
      bus.items[i] = '0;
      for (int k = 0; k < 64; k++) content[i][k] = DAT_W'({$urandom(), $urandom()});
    end
    #1;
    check_cleared();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // All counts zero: nothing granted, addresses stay at zero.
    clear_items();
    start_event();
    repeat (10) tick();
    any_addr = 1'b0;
    for (int i = 0; i < NMEM; i++) if (bus.addr[i] != '0) any_addr = 1'b1;
    check("zero_items_addr", 64'(any_addr), 64'(0));

    // Mixed counts with a gap.
    clear_items();
    ev_items[0] = 3;
    ev_items[2] = 2;
    bus.BX_pipe = 3'd5;
    start_event();
    drain();

    // Maximum count on one memory.
    clear_items();
    ev_items[0] = 63;
    start_event();
    drain();
    check("addr00_last", 64'(bus.addr[0]), 64'(62));

    // New event while mem 0 still has 2 of 5 items left.
    clear_items();
    ev_items[0] = 5;
    ev_items[1] = 3;
    start_event();
    repeat (3) tick();
    clear_items();
    ev_items[0] = 2;
    ev_items[3] = 4;
    start_event();
    drain();

    // Budget exhausted mid-stream, then restored.
    clear_items();
    ev_items[0]  = 4;
    ev_items[1]  = 3;
    ev_items[11] = 5;
    start_event();
    repeat (3) tick();
    bus.clk_cnt = 7'd100;
    repeat (5) tick();
    bus.clk_cnt = 7'd127;
    repeat (2) tick();
    bus.clk_cnt = 7'd0;
    drain();

    // Counts load even while the budget is exhausted.
    clear_items();
    ev_items[4] = 3;
    bus.clk_cnt = 7'd110;
    start_event();
    repeat (4) tick();
    drain();

    // Asynchronous reset between edges during a readout.
    clear_items();
    ev_items[0] = 10;
    ev_items[6] = 2;
    start_event();
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    check_cleared();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Randomized events, budget stalls, BX tags and occasional interruptions.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NMEM; i++) begin
        ev_items[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      end
      start_event();
      ncyc = int'($urandom_range(5, 40));
      for (int c = 0; c < ncyc; c++) begin
        bus.BX_pipe = bx_t'($urandom());
        bus.BX      = BX_W'($urandom());
        bus.clk_cnt = ($urandom_range(0, 5) == 0) ? CLK_CNT_W'($urandom_range(100, 127))
                                                  : CLK_CNT_W'($urandom_range(0, 99));
        tick();
      end
      if (it % 3 == 1) begin
        for (int i = 0; i < NMEM; i++) ev_items[i] = int'($urandom_range(0, 3));
        start_event();
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
